noc_output_port_scheduler: RTL

- Per-output-port wormhole scheduler for the NoC router.
- Arbitrates among NUM_INPUTS input buffers requesting one output port, round-robin at packet granularity.
- Holds the grant from head flit through tail flit.
- Tracks downstream credits so no flit is sent without buffer space; sits between the input-buffer read side and the output crossbar select/register.

---
 rtl/noc_output_port_scheduler_if.sv | 43 ++++
 rtl/noc_output_port_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_scheduler_if.sv
// Handshake bundle between input-buffer read side, downstream credit return and
// the per-output-port wormhole scheduler. Optional perf counters: NOC_SCHED_PERF_EN.
interface noc_output_port_scheduler_if #(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8
);
    localparam int unsigned IDX_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);

    logic [NUM_INPUTS-1:0]   req;
    logic [NUM_INPUTS-1:0]   req_is_tail;
    logic [NUM_INPUTS-1:0]   turn_disable;
    logic [NUM_INPUTS-1:0]   grant;
    logic                    send_out;
    logic [IDX_WIDTH-1:0]    sel_out;
    logic                    is_tail_out;
    logic                    credit_in;
    logic [CREDIT_WIDTH-1:0] credit_count;
    logic                    busy;
    logic                    credit_overflow;
`ifdef NOC_SCHED_PERF_EN
    logic [31:0]             flit_count;
    logic [31:0]             stall_count;
`endif

    // Upstream buffers and downstream credit source drive requests/credits.
    modport master (
        output req, req_is_tail, turn_disable, credit_in,
        input  grant, send_out, sel_out, is_tail_out, credit_count, busy, credit_overflow
`ifdef NOC_SCHED_PERF_EN
        , input flit_count, stall_count
`endif
    );

    // The scheduler consumes requests/credits and produces grant and output controls.
    modport slave (
        input  req, req_is_tail, turn_disable, credit_in,
        output grant, send_out, sel_out, is_tail_out, credit_count, busy, credit_overflow
`ifdef NOC_SCHED_PERF_EN
        , output flit_count, stall_count
`endif
    );
endinterface

// File: rtl/noc_output_port_scheduler.sv
// Per-output-port wormhole scheduler: packet-granular round-robin among inputs,
// grant held head-to-tail, downstream credit tracking.
// Optional flit/stall performance counters are enabled by defining NOC_SCHED_PERF_EN.
module noc_output_port_scheduler #(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8
) (
    input  logic                              clk_noc,
    input  logic                              rst_noc,
    noc_output_port_scheduler_if.slave        port
);
    localparam int unsigned IDX_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [IDX_WIDTH-1:0]    rr_ptr;
    logic [IDX_WIDTH-1:0]    owner;
    logic [CREDIT_WIDTH-1:0] credit_count;
    logic                    credit_overflow;
    logic                    send_out;
    logic [IDX_WIDTH-1:0]    sel_out;
    logic                    is_tail_out;
    logic                    busy;

    logic [NUM_INPUTS-1:0]   cand_c;
    logic                    avail_c;
    logic [IDX_WIDTH-1:0]    scan_c;
    logic                    win_found_c;
    logic [IDX_WIDTH-1:0]    win_idx_c;
    logic                    fire_c;
    logic [IDX_WIDTH-1:0]    gnt_idx_c;
    logic                    gnt_tail_c;
    logic [NUM_INPUTS-1:0]   grant_c;

    // Increment an input index, wrapping from the last input back to 0.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] v);
        return (v == LAST_IDX) ? '0 : IDX_WIDTH'(v + 1'b1);
    endfunction

    assign cand_c  = port.req & ~port.turn_disable;
    assign avail_c = (credit_count != '0);

    // Round-robin search: first eligible input at or after rr_ptr, wrapping.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        scan_c      = rr_ptr;
        for (int k = 0; k < int'(NUM_INPUTS); k++) begin
            if (!win_found_c && cand_c[scan_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = scan_c;
            end
            scan_c = wrap_inc(scan_c);
        end
    end

    // State register.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: lock on a multi-flit head, release on the owner's tail.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (fire_c && !gnt_tail_c) begin
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (fire_c && gnt_tail_c) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Combinational grant: arbitration winner when idle, owner while locked.
    always_comb begin
        fire_c     = 1'b0;
        gnt_idx_c  = owner;
        gnt_tail_c = 1'b0;
        grant_c    = '0;
        unique case (state)
            IDLE: begin
                gnt_idx_c = win_idx_c;
                fire_c    = win_found_c && avail_c;
            end
            LOCKED: begin
                gnt_idx_c = owner;
                fire_c    = port.req[owner] && avail_c;
            end
            default: begin
                fire_c = 1'b0;
            end
        endcase
        if (rst_noc) begin
            fire_c = 1'b0;
        end
        gnt_tail_c = fire_c && port.req_is_tail[gnt_idx_c];
        if (fire_c) begin
            grant_c = NUM_INPUTS'(1) << gnt_idx_c;
        end
    end

    // Arbitration bookkeeping and the one-cycle output register toward the crossbar.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            rr_ptr      <= '0;
            owner       <= '0;
            send_out    <= 1'b0;
            sel_out     <= '0;
            is_tail_out <= 1'b0;
            busy        <= 1'b0;
        end else begin
            send_out    <= fire_c;
            is_tail_out <= gnt_tail_c;
            busy        <= (state_n == LOCKED);
            if (fire_c) begin
                sel_out <= gnt_idx_c;
            end
            if (state == IDLE && fire_c && !gnt_tail_c) begin
                owner <= gnt_idx_c;
            end
            if (gnt_tail_c) begin
                rr_ptr <= wrap_inc(gnt_idx_c);
            end
        end
    end

    // Downstream credit counter; a return at full count is held and flagged sticky.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credit_count    <= CREDIT_FULL;
            credit_overflow <= 1'b0;
        end else begin
            if (fire_c && !port.credit_in) begin
                credit_count <= CREDIT_WIDTH'(credit_count - 1'b1);
            end else if (port.credit_in && !fire_c) begin
                if (credit_count == CREDIT_FULL) begin
                    credit_overflow <= 1'b1;
                end else begin
                    credit_count <= CREDIT_WIDTH'(credit_count + 1'b1);
                end
            end
        end
    end

`ifdef NOC_SCHED_PERF_EN
    logic [31:0] flit_count;
    logic [31:0] stall_count;
    logic        stall_c;

    assign stall_c = ((state == IDLE && cand_c != '0) ||
                      (state == LOCKED && port.req[owner])) && !avail_c;

    // Free-running flit and credit-stall counters, wrapping at 2^32.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            flit_count  <= '0;
            stall_count <= '0;
        end else begin
            if (fire_c) begin
                flit_count <= flit_count + 32'd1;
            end
            if (stall_c) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign port.flit_count  = flit_count;
    assign port.stall_count = stall_count;
`endif

    assign port.grant           = grant_c;
    assign port.send_out        = send_out;
    assign port.sel_out         = sel_out;
    assign port.is_tail_out     = is_tail_out;
    assign port.credit_count    = credit_count;
    assign port.busy            = busy;
    assign port.credit_overflow = credit_overflow;
endmodule
